// File: rtl/pif_pkg.sv
// Shared tag constants, payload width and FSM encoding for the I2C register decoder.
package pif_pkg;

    localparam int I2C_DATA_BITS = 6;

    localparam logic [1:0] A_ADDR = 2'b00;  // load address pointer
    localparam logic [1:0] D_ADDR = 2'b01;  // data write
    localparam logic [1:0] R_ADDR = 2'b10;  // read request
    localparam logic [1:0] X_ADDR = 2'b11;  // reserved

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_RDWAIT = 2'd2
    } pif_state_e;

endpackage

// File: rtl/pif_regfile.sv
// Register storage for the I2C register decoder: one write port, whole array read flattened.
module pif_regfile #(
    parameter int DATA_BITS = 6,
    parameter int NUM_REGS  = 8,
    parameter int ADDR_BITS = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en_i,
    input  logic [ADDR_BITS-1:0]          wr_addr_i,
    input  logic [DATA_BITS-1:0]          wr_data_i,
    output logic [NUM_REGS*DATA_BITS-1:0] rd_flat_o
);

    logic [NUM_REGS*DATA_BITS-1:0] regs_q;

    // Out-of-range addresses match no slot, so they never modify storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs_q <= '0;
        end else if (wr_en_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (wr_addr_i == ADDR_BITS'(i)) begin
                    regs_q[i*DATA_BITS +: DATA_BITS] <= wr_data_i;
                end
            end
        end
    end

    assign rd_flat_o = regs_q;

endmodule

// File: rtl/i2c_reg_decoder.sv
// Decodes tagged I2C bytes into register writes and read-backs.
// Define AUTO_INC_EN to advance the pointer after every write and completed read.
import pif_pkg::*;

module i2c_reg_decoder #(
    parameter int DATA_BITS = 6,
    parameter int NUM_REGS  = 8
) (
    input  logic                          clk,
    input  logic                          sys_rst,
    input  logic                          rx_valid,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_start,
    input  logic                          rx_stop,
    input  logic                          tx_ready,
    output logic                          tx_valid,
    output logic [7:0]                    tx_data,
    output logic [NUM_REGS*DATA_BITS-1:0] reg_q,
    output logic                          wr_strobe,
    output logic                          err,
    output pif_state_e                    dbg_state
);

`ifdef AUTO_INC_EN
    localparam bit AUTO_INC = 1'b1;
`else
    localparam bit AUTO_INC = 1'b0;
`endif

    localparam logic [I2C_DATA_BITS-1:0] LAST_IDX = I2C_DATA_BITS'(NUM_REGS - 1);

    pif_state_e                 state_q, state_d;
    logic [I2C_DATA_BITS-1:0]   ptr_q, ptr_d;
    logic                       tx_valid_q, tx_valid_d;
    logic [7:0]                 tx_data_q, tx_data_d;
    logic                       wr_strobe_q, wr_strobe_d;
    logic                       err_q, err_d;

    logic [1:0]                 tag;
    logic [I2C_DATA_BITS-1:0]   payload;
    logic                       ptr_in_range;
    logic [I2C_DATA_BITS-1:0]   ptr_inc;
    logic [DATA_BITS-1:0]       rd_val;
    logic                       wr_en;

    assign tag          = rx_data[7:6];
    assign payload      = rx_data[I2C_DATA_BITS-1:0];
    assign ptr_in_range = (ptr_q <= LAST_IDX);
    assign ptr_inc      = (ptr_q >= LAST_IDX) ? '0 : ptr_q + I2C_DATA_BITS'(1);

    pif_regfile #(
        .DATA_BITS (DATA_BITS),
        .NUM_REGS  (NUM_REGS),
        .ADDR_BITS (I2C_DATA_BITS)
    ) u_regfile (
        .clk       (clk),
        .rst       (sys_rst),
        .wr_en_i   (wr_en),
        .wr_addr_i (ptr_q),
        .wr_data_i (rx_data[DATA_BITS-1:0]),
        .rd_flat_o (reg_q)
    );

    always_comb begin
        rd_val = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (ptr_q == I2C_DATA_BITS'(i)) begin
                rd_val = reg_q[i*DATA_BITS +: DATA_BITS];
            end
        end
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q     <= ST_IDLE;
            ptr_q       <= '0;
            tx_valid_q  <= 1'b0;
            tx_data_q   <= '0;
            wr_strobe_q <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            tx_valid_q  <= tx_valid_d;
            tx_data_q   <= tx_data_d;
            wr_strobe_q <= wr_strobe_d;
            err_q       <= err_d;
        end
    end

    // Bus events win over any byte in the same cycle; that byte is silently dropped.
    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        tx_valid_d  = tx_valid_q;
        tx_data_d   = tx_data_q;
        wr_strobe_d = 1'b0;
        err_d       = err_q;
        wr_en       = 1'b0;

        if (rx_stop) begin
            state_d    = ST_IDLE;
            tx_valid_d = 1'b0;
        end else if (rx_start) begin
            state_d    = ST_ACTIVE;
            tx_valid_d = 1'b0;
            if (!rx_valid) begin
                err_d = 1'b0;
            end
        end else begin
            case (state_q)
                ST_IDLE: begin
                end
                ST_ACTIVE: begin
                    if (rx_valid) begin
                        case (tag)
                            A_ADDR: ptr_d = payload;
                            D_ADDR: begin
                                if (ptr_in_range) begin
                                    wr_en       = 1'b1;
                                    wr_strobe_d = 1'b1;
                                    if (AUTO_INC) ptr_d = ptr_inc;
                                end else begin
                                    err_d = 1'b1;
                                end
                            end
                            R_ADDR: begin
                                tx_valid_d = 1'b1;
                                tx_data_d  = ptr_in_range ? {D_ADDR, I2C_DATA_BITS'(rd_val)} : 8'h7F;
                                state_d    = ST_RDWAIT;
                            end
                            default: err_d = 1'b1;
                        endcase
                    end
                end
                ST_RDWAIT: begin
                    if (rx_valid) begin
                        err_d = 1'b1;
                    end
                    if (tx_ready) begin
                        tx_valid_d = 1'b0;
                        state_d    = ST_ACTIVE;
                        if (AUTO_INC) ptr_d = ptr_inc;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign tx_valid  = tx_valid_q;
    assign tx_data   = tx_data_q;
    assign wr_strobe = wr_strobe_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_i2c_reg_decoder.sv
// Directed self-checking bench for i2c_reg_decoder; expectations follow AUTO_INC_EN.
import pif_pkg::*;

module tb_i2c_reg_decoder;

    logic        clk;
    logic        sys_rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic        rx_start;
    logic        rx_stop;
    logic        tx_ready;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic [47:0] reg_q;
    logic        wr_strobe;
    logic        err;
    pif_state_e  dbg_state;

    int total;
    int bad;
    logic [5:0] m [8];

    i2c_reg_decoder #(.DATA_BITS(6), .NUM_REGS(8)) dut (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .rx_valid  (rx_valid),
        .rx_data   (rx_data),
        .rx_start  (rx_start),
        .rx_stop   (rx_stop),
        .tx_ready  (tx_ready),
        .tx_valid  (tx_valid),
        .tx_data   (tx_data),
        .reg_q     (reg_q),
        .wr_strobe (wr_strobe),
        .err       (err),
        .dbg_state (dbg_state)
    );

    initial clk = 1'b0;
    always #25 clk = ~clk;

    function automatic logic [47:0] model_flat();
        logic [47:0] f;
        for (int i = 0; i < 8; i++) f[i*6 +: 6] = m[i];
        return f;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    task automatic do_start();
        rx_start = 1'b1;
        tick();
        rx_start = 1'b0;
    endtask

    task automatic do_stop();
        rx_stop = 1'b1;
        tick();
        rx_stop = 1'b0;
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        for (int i = 0; i < 8; i++) m[i] = 6'd0;
        sys_rst  = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        rx_start = 1'b0;
        rx_stop  = 1'b0;
        tx_ready = 1'b0;
        repeat (3) tick();

        check("rst_tx_valid", 64'(tx_valid), 64'd0);
        check("rst_tx_data", 64'(tx_data), 64'h00);
        check("rst_reg_q", 64'(reg_q), 64'd0);
        check("rst_wr_strobe", 64'(wr_strobe), 64'd0);
        check("rst_err", 64'(err), 64'd0);
        check("rst_state", 64'(dbg_state), 64'(ST_IDLE));
        sys_rst = 1'b0;
        tick();

        // Simple write: reg2 <= 1
        do_start();
        check("start_state", 64'(dbg_state), 64'(ST_ACTIVE));
        send_byte(8'h02);
        check("addr_no_strobe", 64'(wr_strobe), 64'd0);
        send_byte(8'h41);
        m[2] = 6'd1;
        check("wr_strobe_pulse", 64'(wr_strobe), 64'd1);
        check("wr_reg2", 64'(reg_q), 64'(model_flat()));
        tick();
        check("wr_strobe_one_cycle", 64'(wr_strobe), 64'd0);
        do_stop();
        check("stop_state", 64'(dbg_state), 64'(ST_IDLE));
        check("wr_err", 64'(err), 64'd0);

        // Read with tx_ready held low for 5 cycles
        do_start();
        send_byte(8'h03);
        send_byte(8'h55);
        m[3] = 6'h15;
        check("wr_reg3", 64'(reg_q), 64'(model_flat()));
        send_byte(8'h03);
        send_byte(8'h80);
        check("rd_tx_valid", 64'(tx_valid), 64'd1);
        check("rd_tx_data", 64'(tx_data), 64'h55);
        check("rd_state", 64'(dbg_state), 64'(ST_RDWAIT));
        for (int i = 0; i < 5; i++) begin
            tick();
            check("rd_hold_valid", 64'(tx_valid), 64'd1);
            check("rd_hold_data", 64'(tx_data), 64'h55);
        end
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("rd_done_valid", 64'(tx_valid), 64'd0);
        check("rd_done_state", 64'(dbg_state), 64'(ST_ACTIVE));

        // Out-of-range read, plus a byte arriving during RDWAIT
        send_byte(8'h0A);
        send_byte(8'h80);
        check("oor_rd_data", 64'(tx_data), 64'h7F);
        check("oor_rd_valid", 64'(tx_valid), 64'd1);
        send_byte(8'h41);
        check("rdwait_byte_err", 64'(err), 64'd1);
        check("rdwait_byte_no_wr", 64'(reg_q), 64'(model_flat()));
        check("rdwait_still_valid", 64'(tx_valid), 64'd1);
        tx_ready = 1'b1;
        tick();
        tx_ready = 1'b0;
        check("oor_rd_done", 64'(tx_valid), 64'd0);
        do_start();
        check("err_clr_start", 64'(err), 64'd0);

        // Out-of-range write and reserved tag
        send_byte(8'h0A);
        send_byte(8'h41);
        check("oor_wr_err", 64'(err), 64'd1);
        check("oor_wr_no_strobe", 64'(wr_strobe), 64'd0);
        check("oor_wr_reg_q", 64'(reg_q), 64'(model_flat()));
        do_start();
        check("oor_err_clr", 64'(err), 64'd0);
        send_byte(8'hC1);
        check("rsvd_tag_err", 64'(err), 64'd1);
        rx_start = 1'b1;
        send_byte(8'h41);
        rx_start = 1'b0;
        check("start_with_byte_keeps_err", 64'(err), 64'd1);
        check("start_with_byte_no_wr", 64'(wr_strobe), 64'd0);
        do_start();
        check("rsvd_err_clr", 64'(err), 64'd0);

        // Pointer wrap / no auto-increment
        send_byte(8'h07);
        send_byte(8'h45);
        send_byte(8'h46);
`ifdef AUTO_INC_EN
        m[7] = 6'd5;
        m[0] = 6'd6;
`else
        m[7] = 6'd6;
`endif
        check("autoinc_regs", 64'(reg_q), 64'(model_flat()));

        // IDLE ignores bytes; STOP beats a same-cycle byte; pointer survives STOP/START
        do_stop();
        send_byte(8'h41);
        check("idle_no_wr", 64'(wr_strobe), 64'd0);
        check("idle_no_err", 64'(err), 64'd0);
        check("idle_reg_q", 64'(reg_q), 64'(model_flat()));
        do_start();
        send_byte(8'h05);
        rx_stop = 1'b1;
        send_byte(8'h41);
        rx_stop = 1'b0;
        check("stop_byte_dropped", 64'(wr_strobe), 64'd0);
        check("stop_byte_reg_q", 64'(reg_q), 64'(model_flat()));
        check("stop_byte_state", 64'(dbg_state), 64'(ST_IDLE));
        do_start();
        send_byte(8'h42);
        m[5] = 6'd2;
        check("ptr_retained", 64'(reg_q), 64'(model_flat()));
        rx_start = 1'b1;
        rx_stop  = 1'b1;
        tick();
        rx_start = 1'b0;
        rx_stop  = 1'b0;
        check("stop_over_start", 64'(dbg_state), 64'(ST_IDLE));

        // Asynchronous reset while waiting in RDWAIT
        do_start();
        send_byte(8'h05);
        send_byte(8'h80);
        check("pre_rst_valid", 64'(tx_valid), 64'd1);
        check("pre_rst_data", 64'(tx_data), 64'h42);
        #10;
        sys_rst = 1'b1;
        #1;
        check("async_rst_valid", 64'(tx_valid), 64'd0);
        check("async_rst_reg_q", 64'(reg_q), 64'd0);
        check("async_rst_state", 64'(dbg_state), 64'(ST_IDLE));
        tick();
        sys_rst = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
